// File: rtl/word_tx_packer.sv
// word_tx_packer
//   Latches a 32-bit readback word on a load strobe and hands it to uart_tx
//   one byte at a time over a start/busy handshake. It returns probed values
//   to the host and shares the clock domain of address_multiplexer and uart_tx.
//
//   Parameters
//     MSB_FIRST    1: send [31:24] first, 0: send [7:0] first
//     ACK_TIMEOUT  cycles allowed for tx_busy to rise after tx_start (2..255)
//
//   Ports
//     Clk         system clock, rising edge
//     Reset       synchronous, active-high reset
//     load        one-cycle strobe, data_in_32 valid in the same cycle
//     data_in_32  word to transmit
//     tx_busy     uart_tx busy flag
//     tx_start    one-cycle send request to uart_tx
//     tx_byte_8   byte presented to uart_tx
//     busy        frame in progress
//     done        one-cycle pulse after the last byte has drained
//     err         one-cycle pulse on ack timeout (frame aborted)
//
//   state | meaning
//   IDLE  | waiting for load
//   START | waiting for the transmitter to be free, then issue tx_start
//   ACK   | waiting for tx_busy to rise, bounded by ACK_TIMEOUT
//   DRAIN | byte in flight, waiting for tx_busy to fall
module word_tx_packer #(
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load,
    input  logic [31:0] data_in_32,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_byte_8,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [31:0] shift_q;
    logic [1:0]  byte_idx;
    logic [7:0]  timer;
    logic [7:0]  cur_byte;

    // The outgoing byte always sits at the same end of the shift register;
    // the register is shifted toward that end after each byte drains.
    always_comb begin
        cur_byte = shift_q[7:0];
        if (MSB_FIRST) begin
            cur_byte = shift_q[31:24];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            byte_idx  <= '0;
            timer     <= '0;
            tx_start  <= 1'b0;
            tx_byte_8 <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shift_q  <= data_in_32;
                        byte_idx <= '0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    // A transmitter still busy with other traffic holds us here.
                    if (!tx_busy) begin
                        tx_byte_8 <= cur_byte;
                        tx_start  <= 1'b1;
                        timer     <= '0;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    if (tx_busy) begin
                        state <= DRAIN;
                    end else if (timer == TIMER_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        if (byte_idx == 2'd3) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            if (MSB_FIRST) begin
                                shift_q <= {shift_q[23:0], 8'h00};
                            end else begin
                                shift_q <= {8'h00, shift_q[31:8]};
                            end
                            state <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_tx_packer.sv
// Testbench for word_tx_packer. Two instances (MSB-first and LSB-first) share
// every input; a behavioural uart_tx model answers the MSB-first instance's
// tx_start, and both must produce the byte order computed from the word.
module tb_word_tx_packer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        load;
    logic [31:0] data_in_32;
    logic        tx_busy;

    logic        tx_start0, busy0, done0, err0;
    logic [7:0]  tx_byte0;
    logic        tx_start1, busy1, done1, err1;
    logic [7:0]  tx_byte1;

    always #5 Clk = ~Clk;

    word_tx_packer #(.MSB_FIRST(1'b1), .ACK_TIMEOUT(16)) dut_msb (
        .Clk(Clk), .Reset(Reset), .load(load), .data_in_32(data_in_32),
        .tx_busy(tx_busy), .tx_start(tx_start0), .tx_byte_8(tx_byte0),
        .busy(busy0), .done(done0), .err(err0)
    );

    word_tx_packer #(.MSB_FIRST(1'b0), .ACK_TIMEOUT(16)) dut_lsb (
        .Clk(Clk), .Reset(Reset), .load(load), .data_in_32(data_in_32),
        .tx_busy(tx_busy), .tx_start(tx_start1), .tx_byte_8(tx_byte1),
        .busy(busy1), .done(done1), .err(err1)
    );

    // uart_tx model: busy rises the cycle after tx_start is sampled and
    // stays high for uart_len cycles. force_busy emulates foreign traffic.
    int   uart_cnt = 0;
    int   uart_len = 10;
    logic uart_en = 1'b1;
    logic force_busy = 1'b0;

    always @(posedge Clk) begin
        if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
        else if (uart_en && tx_start0) uart_cnt <= uart_len;
    end
    assign tx_busy = force_busy || (uart_cnt != 0);

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int n_start, n_done, n_err, n_done1, n_err1;
    int cyc = 0, load_cyc, first_start_cyc, err_cyc, done_cyc, fall_cyc;
    logic prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and record what the DUTs did.
    task automatic step();
        @(negedge Clk);
        cyc++;
        if (!Reset) begin
            if (tx_start0) begin
                q0.push_back(tx_byte0);
                n_start++;
                if (first_start_cyc < 0) first_start_cyc = cyc;
            end
            if (tx_start1) q1.push_back(tx_byte1);
            if (done0) begin n_done++; done_cyc = cyc; end
            if (err0)  begin n_err++;  err_cyc = cyc;  end
            if (done1) n_done1++;
            if (err1)  n_err1++;
        end
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i, input bit msb);
        int sh;
        sh = msb ? 8 * (3 - i) : 8 * i;
        return 8'((w >> sh) & 32'hFF);
    endfunction

    task automatic start_frame(input logic [31:0] w);
        q0.delete(); q1.delete();
        n_start = 0; n_done = 0; n_err = 0; n_done1 = 0; n_err1 = 0;
        first_start_cyc = -1; err_cyc = -1; done_cyc = -1;
        data_in_32 = w;
        load = 1'b1;
        step();
        load = 1'b0;
        load_cyc = cyc;
    endtask

    task automatic wait_end();
        int t = 0;
        while (n_done + n_err == 0 && t < 2000) begin step(); t++; end
        check("frame_end_timeout", 32'(n_done + n_err != 0), 32'd1);
    endtask

    task automatic wait_starts(input int n);
        int t = 0;
        while (n_start < n && t < 500) begin step(); t++; end
        check("start_wait_timeout", 32'(n_start >= n), 32'd1);
    endtask

    task automatic finish_frame(input logic [31:0] w, input bit chk_lat);
        logic [7:0] o0, o1;
        wait_end();
        step();
        check("n_tx_start", n_start, 4);
        check("n_done_msb", n_done, 1);
        check("n_err_msb", n_err, 0);
        check("n_done_lsb", n_done1, 1);
        check("n_err_lsb", n_err1, 0);
        for (int i = 0; i < 4; i++) begin
            o0 = (i < q0.size()) ? q0[i] : 8'h00;
            o1 = (i < q1.size()) ? q1[i] : 8'h00;
            check($sformatf("byte_msb[%0d]", i), o0, exp_byte(w, i, 1'b1));
            check($sformatf("byte_lsb[%0d]", i), o1, exp_byte(w, i, 1'b0));
        end
        check("done_after_fall", done_cyc, fall_cyc + 1);
        check("busy_after_msb", busy0, 1'b0);
        check("busy_after_lsb", busy1, 1'b0);
        check("hold_last_msb", tx_byte0, exp_byte(w, 3, 1'b1));
        check("hold_last_lsb", tx_byte1, exp_byte(w, 3, 1'b0));
        if (chk_lat) check("start_latency", first_start_cyc, load_cyc + 1);
    endtask

    initial begin
        logic [31:0] w;
        Reset = 1'b1; load = 1'b0; data_in_32 = '0;
        step(); step();
        check("rst_outputs_msb", {tx_start0, tx_byte0, busy0, done0, err0}, 0);
        check("rst_outputs_lsb", {tx_start1, tx_byte1, busy1, done1, err1}, 0);
        Reset = 1'b0;
        step();

        // Normal frame; the LSB-first instance covers 0x01020304 ordering too.
        uart_len = 10;
        start_frame(32'hDEADBEEF);
        check("busy_on_load", busy0, 1'b1);
        finish_frame(32'hDEADBEEF, 1'b1);
        uart_len = 10;
        start_frame(32'h01020304);
        finish_frame(32'h01020304, 1'b1);

        // Randomized words and transmitter busy lengths.
        for (int f = 0; f < 6; f++) begin
            w = $urandom;
            uart_len = $urandom_range(1, 12);
            start_frame(w);
            finish_frame(w, 1'b1);
            repeat ($urandom_range(0, 3)) step();
        end

        // Transmitter occupied around load.
        uart_len = 10;
        force_busy = 1'b1;
        repeat (5) step();
        start_frame(32'h3C5A96F0);
        repeat (14) step();
        check("occupied_no_start", n_start, 0);
        force_busy = 1'b0;
        step();
        check("occupied_release_start", tx_start0, 1'b1);
        finish_frame(32'h3C5A96F0, 1'b0);

        // Ack timeout.
        uart_en = 1'b0;
        start_frame(32'h12345678);
        wait_end();
        step();
        check("to_n_start", n_start, 1);
        check("to_byte_msb", (q0.size() > 0) ? q0[0] : 8'h00, 8'h12);
        check("to_byte_lsb", (q1.size() > 0) ? q1[0] : 8'h00, 8'h78);
        check("to_n_err", n_err, 1);
        check("to_n_done", n_done, 0);
        check("to_n_err_lsb", n_err1, 1);
        check("to_err_delay", err_cyc - first_start_cyc, 16);
        check("to_busy", busy0, 1'b0);
        check("to_hold_byte", tx_byte0, 8'h12);
        uart_en = 1'b1;
        repeat (3) step();

        // load during a frame is ignored.
        uart_len = 6;
        start_frame(32'hAAAAAAAA);
        wait_starts(2);
        data_in_32 = 32'h55555555;
        load = 1'b1;
        step();
        load = 1'b0;
        finish_frame(32'hAAAAAAAA, 1'b1);
        repeat (20) step();
        check("no_second_word", n_start, 4);
        check("idle_busy", busy0, 1'b0);

        // Reset while byte 1 drains, then a fresh frame.
        uart_len = 10;
        start_frame($urandom);
        wait_starts(2);
        repeat (3) step();
        check("pre_rst_busy", busy0, 1'b1);
        Reset = 1'b1;
        step();
        check("midrst_msb", {tx_start0, tx_byte0, busy0, done0, err0}, 0);
        check("midrst_lsb", {tx_start1, tx_byte1, busy1, done1, err1}, 0);
        Reset = 1'b0;
        start_frame(32'hCAFEF00D);
        finish_frame(32'hCAFEF00D, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
